// File: rtl/counter_pkg.sv
// Shared constants for the counter bank and its lanes.
package counter_pkg;

    localparam logic DirUp    = 1'b1;
    localparam logic DirDown  = 1'b0;
    localparam int   DefWidth = 8;

endpackage

// File: rtl/counter_lane.sv
// One modulo counter channel: value and sticky overflow registers,
// next-state selection and the terminal/wrap decode.
module counter_lane
    import counter_pkg::*;
#(
    parameter type value_t = logic [DefWidth-1:0]
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   step_i,
    input  logic   up_i,
    input  logic   clr_i,
    input  logic   load_i,
    input  value_t load_value_i,
    input  value_t limit_i,
    input  logic   ovf_clr_i,
    output value_t value_o,
    output logic   wrap_o,
    output logic   ovf_o
);

    value_t r_value;
    logic   r_ovf;
    logic   w_terminal;
    value_t w_next;

    // Terminal decode: top of range going up, zero going down. A down-step
    // from above the limit reloads but is deliberately not a terminal event.
    always_comb begin
        w_terminal = 1'b0;
        if (up_i == DirDown) begin
            w_terminal = (r_value == '0);
        end else begin
            w_terminal = (r_value >= limit_i);
        end
    end

    // clr and load both suppress the wrap so a chained neighbour does not step.
    assign wrap_o = step_i && !clr_i && !load_i && w_terminal;

    // Next value with priority clr > load > step > hold.
    always_comb begin
        w_next = r_value;
        if (clr_i) begin
            w_next = '0;
        end else if (load_i) begin
            w_next = load_value_i;
        end else if (step_i) begin
            if (up_i == DirUp) begin
                w_next = w_terminal ? '0 : r_value + value_t'(1);
            end else if ((r_value == '0) || (r_value > limit_i)) begin
                w_next = limit_i;
            end else begin
                w_next = r_value - value_t'(1);
            end
        end
    end

    // Value and sticky flag registers; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_value <= w_next;
            r_ovf   <= (r_ovf && !ovf_clr_i) || wrap_o;
        end
    end

    assign value_o = r_value;
    assign ovf_o   = r_ovf;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent modulo counters. Each channel either counts on its own
// enable or, when chained, on the wrap of the channel directly below it.
module counter_bank
    import counter_pkg::*;
#(
    parameter int  NumCh   = 4,
    parameter int  Width   = DefWidth,
    parameter type value_t = logic [Width-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumCh-1:0]             en_i,
    input  logic [NumCh-1:0]             up_i,
    input  logic [NumCh-1:0]             clr_i,
    input  logic [NumCh-1:0]             load_i,
    input  logic [NumCh-1:0][Width-1:0]  load_value_i,
    input  logic [NumCh-1:0][Width-1:0]  limit_i,
    input  logic [NumCh-1:0]             chain_i,
    input  logic [NumCh-1:0]             ovf_clr_i,
    output logic [NumCh-1:0][Width-1:0]  value_o,
    output logic [NumCh-1:0]             wrap_o,
    output logic [NumCh-1:0]             ovf_o
);

    // Channel 0 has nothing below it, so its chain bit has no meaning.
    logic w_unused_chain0;
    assign w_unused_chain0 = chain_i[0];

    // Per-lane step mux; the wrap ripples upward only, so there is no loop.
    for (genvar k = 0; k < NumCh; k++) begin : g_lane
        logic w_step;
        logic w_wrap;

        if (k == 0) begin : g_base
            assign w_step = en_i[0];
        end else begin : g_chain
            assign w_step = chain_i[k] ? g_lane[k-1].w_wrap : en_i[k];
        end

        counter_lane #(
            .value_t (value_t)
        ) u_lane (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .step_i       (w_step),
            .up_i         (up_i[k]),
            .clr_i        (clr_i[k]),
            .load_i       (load_i[k]),
            .load_value_i (load_value_i[k]),
            .limit_i      (limit_i[k]),
            .ovf_clr_i    (ovf_clr_i[k]),
            .value_o      (value_o[k]),
            .wrap_o       (w_wrap),
            .ovf_o        (ovf_o[k])
        );

        assign wrap_o[k] = w_wrap;
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank with a queue of expected results.
module tb_counter_bank;

    localparam int NumCh = 4;
    localparam int Width = 8;

    logic                        clk_i;
    logic                        rst_i;
    logic [NumCh-1:0]            en_i;
    logic [NumCh-1:0]            up_i;
    logic [NumCh-1:0]            clr_i;
    logic [NumCh-1:0]            load_i;
    logic [NumCh-1:0][Width-1:0] load_value_i;
    logic [NumCh-1:0][Width-1:0] limit_i;
    logic [NumCh-1:0]            chain_i;
    logic [NumCh-1:0]            ovf_clr_i;
    logic [NumCh-1:0][Width-1:0] value_o;
    logic [NumCh-1:0]            wrap_o;
    logic [NumCh-1:0]            ovf_o;

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int seq[6] = '{7, 3, 2, 1, 0, 3};

    counter_bank #(.NumCh(NumCh), .Width(Width)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .up_i         (up_i),
        .clr_i        (clr_i),
        .load_i       (load_i),
        .load_value_i (load_value_i),
        .limit_i      (limit_i),
        .chain_i      (chain_i),
        .ovf_clr_i    (ovf_clr_i),
        .value_o      (value_o),
        .wrap_o       (wrap_o),
        .ovf_o        (ovf_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic int nxt_up(int v, int lim);
        return (v >= lim) ? 0 : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%0d", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
        end
    endtask

    initial begin
        int m;
        int m0;
        int m1;
        int pulses;
        logic w0;
        logic w1;

        rst_i        = 1'b1;
        en_i         = '0;
        up_i         = '0;
        clr_i        = '0;
        load_i       = '0;
        load_value_i = '0;
        limit_i      = '0;
        chain_i      = '0;
        ovf_clr_i    = '0;

        // reset state
        for (int k = 0; k < NumCh; k++) push(0);
        push(0);
        tick();
        tick();
        for (int k = 0; k < NumCh; k++) check("rst_val", 32'(value_o[k]));
        check("rst_ovf", 32'(ovf_o));

        // up-count, limit 5
        rst_i      = 1'b0;
        up_i       = '1;
        limit_i[0] = 8'd5;
        en_i[0]    = 1'b1;
        m = 0;
        push(0);
        #1;
        for (int i = 0; i <= 8; i++) begin
            check("up_val", 32'(value_o[0]));
            push((m == 5) ? 1 : 0);
            check("up_wrap", 32'(wrap_o[0]));
            push((i >= 6) ? 1 : 0);
            check("up_ovf", 32'(ovf_o[0]));
            if (i < 8) begin
                m = nxt_up(m, 5);
                push(32'(m));
                tick();
            end
        end
        en_i[0] = 1'b0;

        // down-count after out-of-range load
        limit_i[1]      = 8'd3;
        up_i[1]         = 1'b0;
        load_i[1]       = 1'b1;
        load_value_i[1] = 8'd7;
        push(7);
        tick();
        load_i[1] = 1'b0;
        en_i[1]   = 1'b1;
        #1;
        for (int i = 0; i <= 5; i++) begin
            check("dn_val", 32'(value_o[1]));
            push((seq[i] == 0) ? 1 : 0);
            check("dn_wrap", 32'(wrap_o[1]));
            if (i < 5) begin
                push(32'(seq[i+1]));
                tick();
            end
        end
        en_i[1] = 1'b0;

        // cascade ch0 (0..9) into ch1 (0..5)
        clr_i[1:0]     = 2'b11;
        ovf_clr_i[1:0] = 2'b11;
        tick();
        clr_i     = '0;
        ovf_clr_i = '0;
        up_i[1]    = 1'b1;
        limit_i[0] = 8'd9;
        limit_i[1] = 8'd5;
        chain_i[1] = 1'b1;
        en_i[0]    = 1'b1;
        #1;
        m0 = 0;
        m1 = 0;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            w0 = (m0 >= 9);
            w1 = w0 && (m1 >= 5);
            push(32'(w1));
            check("cas_wrap1", 32'(wrap_o[1]));
            if (wrap_o[1] === 1'b1) pulses++;
            if (c % 10 == 0) begin
                push(32'(m1));
                check("cas_val1", 32'(value_o[1]));
            end
            if (w0) m1 = nxt_up(m1, 5);
            m0 = nxt_up(m0, 9);
            tick();
        end
        push(32'(m0));
        check("cas_end0", 32'(value_o[0]));
        push(32'(m1));
        check("cas_end1", 32'(value_o[1]));
        push(1);
        check("cas_pulses", 32'(pulses));
        en_i[0]    = 1'b0;
        chain_i[1] = 1'b0;

        // priority: clr > load > step
        limit_i[2]      = 8'd4;
        load_i[2]       = 1'b1;
        load_value_i[2] = 8'd4;
        push(4);
        tick();
        check("pri_pre", 32'(value_o[2]));
        clr_i[2]        = 1'b1;
        load_value_i[2] = 8'd2;
        en_i[2]         = 1'b1;
        #1;
        push(0);
        check("pri_clr_wrap", 32'(wrap_o[2]));
        push(0);
        tick();
        check("pri_clr_val", 32'(value_o[2]));
        push(0);
        check("pri_clr_ovf", 32'(ovf_o[2]));
        clr_i[2]        = 1'b0;
        en_i[2]         = 1'b0;
        load_value_i[2] = 8'd4;
        push(4);
        tick();
        check("pri_pre2", 32'(value_o[2]));
        load_value_i[2] = 8'd2;
        en_i[2]         = 1'b1;
        #1;
        push(0);
        check("pri_ld_wrap", 32'(wrap_o[2]));
        push(2);
        tick();
        check("pri_ld_val", 32'(value_o[2]));
        push(0);
        check("pri_ld_ovf", 32'(ovf_o[2]));
        load_i[2] = 1'b0;
        en_i[2]   = 1'b0;

        // sticky flag: set beats clear
        limit_i[0]      = 8'd5;
        load_i[0]       = 1'b1;
        load_value_i[0] = 8'd5;
        push(5);
        tick();
        check("stk_pre_val", 32'(value_o[0]));
        push(1);
        check("stk_pre_ovf", 32'(ovf_o[0]));
        load_i[0]    = 1'b0;
        en_i[0]      = 1'b1;
        ovf_clr_i[0] = 1'b1;
        #1;
        push(1);
        check("stk_wrap", 32'(wrap_o[0]));
        push(1);
        push(0);
        tick();
        check("stk_set_wins", 32'(ovf_o[0]));
        check("stk_val", 32'(value_o[0]));
        en_i[0] = 1'b0;
        #1;
        push(0);
        check("stk_nowrap", 32'(wrap_o[0]));
        push(0);
        tick();
        check("stk_cleared", 32'(ovf_o[0]));
        ovf_clr_i[0] = 1'b0;

        // limit 0 on ch3, other channels running, then reset mid-count
        limit_i[3] = 8'd0;
        en_i[3]    = 1'b1;
        en_i[0]    = 1'b1;
        en_i[2]    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_i[3] = (i < 2);
            #1;
            push(1);
            check("lim0_wrap", 32'(wrap_o[3]));
            push(0);
            tick();
            check("lim0_val", 32'(value_o[3]));
        end
        push(1);
        check("lim0_ovf", 32'(ovf_o[3]));
        rst_i = 1'b1;
        for (int k = 0; k < NumCh; k++) push(0);
        push(0);
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < NumCh; k++) check("mid_rst_val", 32'(value_o[k]));
        check("mid_rst_ovf", 32'(ovf_o));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Bank of NumCh independent modulo counters, each Width bits wide. Successor to the single fixed-limit counter.
- Per-channel features: runtime-programmable terminal value, up/down direction, parallel load, sticky overflow flag.
- Optional cascading: a channel can advance on the wrap of the channel below it, so channels form wider or mixed-radix counters.
- Used for timers, event counters and time-of-day style counters in the datapath/control layer.

Parameters:
- NumCh, 4, number of counter channels (>=1)
- Width, 8, bits per channel value (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  [NumCh-1:0]  per-channel count enable (ignored when channel is chained)
- up_i  in  [NumCh-1:0]  direction: 1 = up, 0 = down
- clr_i  in  [NumCh-1:0]  synchronous clear to 0
- load_i  in  [NumCh-1:0]  synchronous load of load_value_i
- load_value_i  in  [NumCh-1:0][Width-1:0]  load data
- limit_i  in  [NumCh-1:0][Width-1:0]  terminal value; channel counts 0..limit
- chain_i  in  [NumCh-1:0]  1 = step on wrap_o[k-1] instead of en_i[k]; bit 0 ignored
- ovf_clr_i  in  [NumCh-1:0]  clear sticky overflow flag
- value_o  out  [NumCh-1:0][Width-1:0]  current counter values (registered)
- wrap_o  out  [NumCh-1:0]  combinational: channel wraps at the next edge
- ovf_o  out  [NumCh-1:0]  sticky overflow flags (registered)

Behaviour:
- One clock; reset is synchronous and active-high on rst_i. Reset dominates everything: all value_o = 0, all ovf_o = 0. wrap_o then follows from the reset state and the inputs.
- Step enable per channel k:
  - step[k] = (k>0 && chain_i[k]) ? wrap_o[k-1] : en_i[k].
  - The chain is a combinational ripple from channel 0 upward. There are no loops, because chain only looks downward.
- Per-channel priority at each edge: clr_i > load_i > step > hold.
  - clr: value <= 0.
  - load: value <= load_value_i. No clamping to limit.
  - step, up: if value >= limit then value <= 0, else value <= value+1.
  - step, down: if value == 0 or value > limit then value <= limit, else value <= value-1.
- wrap_o[k] = step[k] && !clr_i[k] && !load_i[k] && terminal[k].
  - terminal, up: value >= limit.
  - terminal, down: value == 0.
  - A down-step from value > limit reloads to limit but is NOT a wrap.
- Consequence of the wrap_o definition: a clr or load on channel k suppresses wrap_o[k], which stops propagation to chained channel k+1 in that cycle.
- Sticky flag: ovf <= (ovf && !ovf_clr_i) || wrap_o. If set and clear land in the same cycle, set wins.
- limit = 0: up and down both hold value at 0 and assert wrap_o on every step.
- limit = 2^Width-1: plain binary counter, with wrap at all-ones (up) or at 0 (down).
- Limit or direction changing mid-count: takes effect on the next edge. No state besides value and ovf.
- Latency: value_o and ovf_o update one cycle after the qualifying inputs. wrap_o has zero latency.
- Arithmetic is Width bits, and compares are unsigned. value+1 is never taken at all-ones, because the terminal check intercepts it first.

Decomposition:
- Package counter_pkg:
  - typedef of the value type, parameterised by Width through a parameterised type in the top-level module.
  - localparam constants DirUp = 1'b1 and DirDown = 1'b0.
- Sub-module counter_lane: one channel holding value and ovf registers, next-state logic and the terminal/wrap decode.
  - Ports: clk_i, rst_i, step_i, up_i, clr_i, load_i, load_value_i, limit_i, ovf_clr_i, value_o, wrap_o, ovf_o.
- counter_bank generates NumCh lanes and the step/chain mux.

Test Plan:
- Reset and up-count:
  - Stimulus: rst_i=1 for 2 cycles; then ch0 up, limit=5, en=1 for 8 cycles.
  - Required: value_o[0] sequence 0,1,2,3,4,5,0,1,2. wrap_o[0] high only while value=5. ovf_o[0]=1 from the cycle after the wrap.
- Down-count with out-of-range load:
  - Stimulus: ch1 limit=3, up=0; load 7; then step 5 cycles.
  - Required: values 7,3,2,1,0,3. wrap_o[1] only at value 0, not at the 7->3 reload.
- Cascade:
  - Stimulus: ch0 limit=9, ch1 limit=5, chain_i[1]=1, en_i[0]=1 for 60 cycles.
  - Required: ch1 increments once per 10 cycles. After 60 cycles ch0=0 and ch1=0. wrap_o[1] pulses once, at cycle 59.
- Priority:
  - Stimulus: ch2 value=4, limit=4, up, with clr_i, load_i (value 2) and en_i all high together.
  - Required: value becomes 0, wrap_o[2]=0, ovf unchanged.
  - Repeat without clr. Required: value becomes 2, no wrap.
- Sticky set/clear collision:
  - Stimulus: ovf_o[0]=1; assert ovf_clr_i[0] in the same cycle as a wrap.
  - Required: ovf_o stays 1. Next cycle, ovf_clr alone with no wrap: ovf_o=0.
- limit=0 and mid-operation reset:
  - Stimulus: ch3 limit=0, en=1; then assert rst_i during counting on other channels.
  - Required: ch3 value stays 0 with wrap_o[3]=1 on every step. One cycle after rst_i, all values and ovf flags are 0.
